ervp_counter_reset_cells: RTL and testbench
===========================================

# ervp_counter_reset_cells

Parameterised up-counter (`ERVP_COUNTER`) with first/last flags, plus two combinational reset-net cells, `RESET_BUF` and `RESET_NOT`. The platform reset controller uses the counter to pace its reset sequence: each reset step waits a fixed number of clock cycles. The controller uses the cells to buffer and invert every distributed reset net, so they can later be swapped for technology-specific reset-tree cells.

## Interface
Parameters (`ERVP_COUNTER`):
- `BW_COUNTER`, default 8: counter width in bits; terminal value is 2^BW_COUNTER − 1.
- `CIRCULAR`, default 0:
  - 1: the counter wraps from terminal to 0.
  - 0: the counter saturates at terminal.

Ports (`ERVP_COUNTER`):
- `clk` input 1: the single clock; all state changes on the rising edge.
- `rstnn` input 1: asynchronous, active-low reset.
- `enable` input 1: qualifies `init` and `count`; when 0, `value` holds.
- `init` input 1: synchronous clear of `value` to 0.
- `count` input 1: increment request.
- `value` output BW_COUNTER: current count; may be left unconnected.
- `is_first_count` output 1: high while `value` == 0.
- `is_last_count` output 1: high while `value` == 2^BW_COUNTER − 1.

Ports (`RESET_BUF` / `RESET_NOT`):
- `I` input 1: reset net in.
- `O` output 1: reset net out.
  - `RESET_BUF`: O = I.
  - `RESET_NOT`: O = ~I.

## Operation
- The counter has one BW_COUNTER-bit register, `value`.
- Next-state priority each rising `clk` edge:
  1. `rstnn` = 0 (asynchronous): `value` = 0.
  2. `enable` = 0: hold.
  3. `init` = 1: `value` = 0, regardless of `count`.
  4. `count` = 1 and `value` < terminal: `value` + 1.
  5. `count` = 1 and `value` == terminal: CIRCULAR=1 gives 0; CIRCULAR=0 holds terminal.
  6. Otherwise: hold.
- Arithmetic is unsigned modulo 2^BW_COUNTER; there is no carry or overflow output.
- `is_first_count` and `is_last_count` are combinational decodes of the registered `value`. They are glitch-free relative to `clk` and carry no input-to-output combinational path.
- With BW_COUNTER = 1, the flags alternate with `value`. Both are never high together for BW_COUNTER ≥ 1.
- `RESET_BUF` / `RESET_NOT`:
  - Purely combinational, no state, no clock.
  - A 0→1 or 1→0 edge on `I` propagates to `O` immediately (zero-delay in RTL).
  - Must be usable on asynchronous reset nets, including the driver of `rstnn` itself.

## Timing
- Reset values: `value` = 0, `is_first_count` = 1, `is_last_count` = 0 (for BW_COUNTER ≥ 1).
- Reset assertion takes effect without a clock edge. Deassertion is honoured at the next rising edge after `rstnn` rises.
- Latency:
  - `count` sampled high at edge N: `value`, and the flags, update just after edge N.
  - Reaching terminal from 0 with `count` held high takes 2^BW_COUNTER − 1 edges.
  - `is_last_count` is high during the following cycle.
- `init` and `count` both high in the same cycle: `init` wins and `value` = 0 after the edge.
- A pulse of `init` at terminal, issued in the same cycle the consumer sees `is_last_count`, restarts the count at 0 on the next edge. No cycle is spent at terminal + 1.
- Reset mid-count returns `value` to 0 immediately; counting resumes only after deassertion.

## Test plan
- Reset check, BW_COUNTER = 6, CIRCULAR = 0:
  - Assert `rstnn` = 0 mid-count at `value` = 17 → `value` = 0 without a clock, `is_first_count` = 1.
  - Release `rstnn`, then hold `count` = 1 → `value` = 1, 2, … on successive edges.
- Saturation, BW_COUNTER = 6, CIRCULAR = 0:
  - Hold `count` for 63 edges → `value` = 63, `is_last_count` = 1.
  - Hold 5 more edges → `value` stays 63.
- Wrap, BW_COUNTER = 6, CIRCULAR = 1:
  - Count to 63, then one more edge → `value` = 0, `is_first_count` = 1, `is_last_count` = 0.
- Priority and enable:
  - `init` = `count` = 1 at `value` = 40 → `value` = 0.
  - `enable` = 0 with `count` = 1 for 10 edges → `value` unchanged.
- Reset-controller usage:
  - `count` held high; `init` driven as `count` & `is_last_count` → one `is_last_count` pulse every 64 cycles, `value` sequence 0…63, 0….
- Cells:
  - Drive `I` = 0, 1, 0 → `RESET_BUF.O` = 0, 1, 0 and `RESET_NOT.O` = 1, 0, 1, with no clock present.

Source files
------------

// File: rtl/ervp_counter_reset_cells.sv
// ervp_counter_reset_cells: top-level wrapper that exposes one ERVP_COUNTER
// together with one RESET_BUF and one RESET_NOT cell. The platform reset
// controller uses the counter to pace each reset step, and the two cells to
// buffer and invert the distributed reset nets.

module ervp_counter_reset_cells #(
    parameter int BW_COUNTER = 8,
    parameter int CIRCULAR   = 0
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  enable,
    input  logic                  init,
    input  logic                  count,
    output logic [BW_COUNTER-1:0] value,
    output logic                  is_first_count,
    output logic                  is_last_count,
    input  logic                  buf_net,
    output logic                  buf_drive,
    input  logic                  not_net,
    output logic                  not_drive
);

    ERVP_COUNTER #(
        .BW_COUNTER (BW_COUNTER),
        .CIRCULAR   (CIRCULAR)
    ) counter (
        .clk            (clk),
        .rstnn          (rstnn),
        .enable         (enable),
        .init           (init),
        .count          (count),
        .value          (value),
        .is_first_count (is_first_count),
        .is_last_count  (is_last_count)
    );

    RESET_BUF reset_buf (
        .I (buf_net),
        .O (buf_drive)
    );

    RESET_NOT reset_not (
        .I (not_net),
        .O (not_drive)
    );

endmodule

// ERVP_COUNTER: up-counter with synchronous clear and first/last flags.
// The terminal value is all-ones; CIRCULAR selects wrap-to-zero or saturation
// when a count request arrives at terminal.
module ERVP_COUNTER #(
    parameter int BW_COUNTER = 8,
    parameter int CIRCULAR   = 0
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  enable,
    input  logic                  init,
    input  logic                  count,
    output logic [BW_COUNTER-1:0] value,
    output logic                  is_first_count,
    output logic                  is_last_count
);

    localparam logic [BW_COUNTER-1:0] TERMINAL = '1;

    logic [BW_COUNTER-1:0] value_reg;

    // Count register: enable gates everything, init beats count, and at
    // terminal the counter either wraps to zero or stays put.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            value_reg <= '0;
        end else if (enable) begin
            if (init) begin
                value_reg <= '0;
            end else if (count) begin
                if (value_reg != TERMINAL) begin
                    value_reg <= value_reg + 1'b1;
                end else if (CIRCULAR != 0) begin
                    value_reg <= '0;
                end
            end
        end
    end

    // Flags decode only the registered value, so they never see the inputs
    // combinationally and cannot glitch between clock edges.
    assign value          = value_reg;
    assign is_first_count = (value_reg == '0);
    assign is_last_count  = (value_reg == TERMINAL);

endmodule

// RESET_BUF: plain reset-net buffer, kept as its own cell so it can be
// replaced by a technology reset-tree buffer.
module RESET_BUF (
    input  logic I,
    output logic O
);

    assign O = I;

endmodule

// RESET_NOT: reset-net inverter, converting between active-high and
// active-low reset polarity; also swappable for a technology cell.
module RESET_NOT (
    input  logic I,
    output logic O
);

    assign O = ~I;

endmodule

// File: tb/tb_ervp_counter_reset_cells.sv
// Testbench for ervp_counter_reset_cells: three counter instances (6-bit
// saturating, 6-bit circular, 1-bit circular) share one stimulus stream and
// are compared every cycle against an arithmetic model, with directed literal
// checks pinning the key points of each scenario.

module tb_ervp_counter_reset_cells;

    logic       clk;
    logic       clk_run;
    logic       rstnn;
    logic       enable;
    logic       init;
    logic       count;
    logic       loop_on;
    logic       init_eff;
    logic       buf_net;
    logic       not_net;

    logic [5:0] value_s;
    logic       first_s;
    logic       last_s;
    logic       buf_drive_s;
    logic       not_drive_s;

    logic [5:0] value_c;
    logic       first_c;
    logic       last_c;
    logic       buf_drive_c;
    logic       not_drive_c;

    logic [0:0] value_1;
    logic       first_1;
    logic       last_1;
    logic       buf_drive_1;
    logic       not_drive_1;

    int tests_run = 0;
    int tests_failed = 0;

    int exp_s = 0;
    int exp_c = 0;
    int exp_1 = 0;

    int pulses = 0;
    int first_pulse = -1;
    int second_pulse = -1;

    // Reset-controller style feedback: clear the count on the cycle the
    // circular counter reports terminal.
    assign init_eff = init | (loop_on & count & last_c);

    ervp_counter_reset_cells #(.BW_COUNTER(6), .CIRCULAR(0)) dut_sat (
        .clk(clk), .rstnn(rstnn), .enable(enable), .init(init_eff), .count(count),
        .value(value_s), .is_first_count(first_s), .is_last_count(last_s),
        .buf_net(buf_net), .buf_drive(buf_drive_s),
        .not_net(not_net), .not_drive(not_drive_s)
    );

    ervp_counter_reset_cells #(.BW_COUNTER(6), .CIRCULAR(1)) dut_circ (
        .clk(clk), .rstnn(rstnn), .enable(enable), .init(init_eff), .count(count),
        .value(value_c), .is_first_count(first_c), .is_last_count(last_c),
        .buf_net(buf_net), .buf_drive(buf_drive_c),
        .not_net(not_net), .not_drive(not_drive_c)
    );

    ervp_counter_reset_cells #(.BW_COUNTER(1), .CIRCULAR(1)) dut_one (
        .clk(clk), .rstnn(rstnn), .enable(enable), .init(init_eff), .count(count),
        .value(value_1), .is_first_count(first_1), .is_last_count(last_1),
        .buf_net(buf_net), .buf_drive(buf_drive_1),
        .not_net(not_net), .not_drive(not_drive_1)
    );

    // Free-running clock that can be held off for the clockless cell checks.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Next count from the operating rules, using plain modular arithmetic.
    function automatic int nextVal(input int cur, input int bw, input bit circ,
                                   input bit en, input bit ini, input bit cnt);
        int term;
        term = (1 << bw) - 1;
        if (!en)  return cur;
        if (ini)  return 0;
        if (!cnt) return cur;
        if (circ) return (cur + 1) % (term + 1);
        return (cur + 1 > term) ? term : cur + 1;
    endfunction

    // Reference model: reads the pre-edge inputs on every rising edge.
    always @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            exp_s = 0;
            exp_c = 0;
            exp_1 = 0;
        end else begin
            exp_s = nextVal(exp_s, 6, 1'b0, enable, init_eff, count);
            exp_c = nextVal(exp_c, 6, 1'b1, enable, init_eff, count);
            exp_1 = nextVal(exp_1, 1, 1'b1, enable, init_eff, count);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        checkOutput("sat.value", int'(value_s), exp_s);
        checkOutput("sat.first", int'(first_s), int'(exp_s == 0));
        checkOutput("sat.last",  int'(last_s),  int'(exp_s == 63));
        checkOutput("circ.value", int'(value_c), exp_c);
        checkOutput("circ.first", int'(first_c), int'(exp_c == 0));
        checkOutput("circ.last",  int'(last_c),  int'(exp_c == 63));
        checkOutput("one.value", int'(value_1), exp_1);
        checkOutput("one.first", int'(first_1), int'(exp_1 == 0));
        checkOutput("one.last",  int'(last_1),  int'(exp_1 == 1));
    end

    task automatic applyStimulus(input logic en, input logic ini, input logic cnt);
        enable = en;
        init   = ini;
        count  = cnt;
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clk_run = 1'b0;
        rstnn   = 1'b0;
        loop_on = 1'b0;
        buf_net = 1'b0;
        not_net = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset cells with no clock toggling.
        #1;
        checkOutput("buf.O(I=0)", int'(buf_drive_s), 0);
        checkOutput("not.O(I=0)", int'(not_drive_s), 1);
        buf_net = 1'b1;
        not_net = 1'b1;
        #1;
        checkOutput("buf.O(I=1)", int'(buf_drive_s), 1);
        checkOutput("not.O(I=1)", int'(not_drive_s), 0);
        buf_net = 1'b0;
        not_net = 1'b0;
        #1;
        checkOutput("buf.O(I=0 again)", int'(buf_drive_s), 0);
        checkOutput("not.O(I=0 again)", int'(not_drive_s), 1);

        // Reset state.
        checkOutput("reset.value", int'(value_s), 0);
        checkOutput("reset.first", int'(first_s), 1);
        checkOutput("reset.last",  int'(last_s), 0);
        checkOutput("reset.one.first", int'(first_1), 1);

        clk_run = 1'b1;
        #4;
        rstnn = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        runCycles(17);
        checkOutput("count17.sat", int'(value_s), 17);
        checkOutput("count17.circ", int'(value_c), 17);

        // Asynchronous reset mid-count.
        #2;
        rstnn = 1'b0;
        #1;
        checkOutput("async_rst.value", int'(value_s), 0);
        checkOutput("async_rst.first", int'(first_s), 1);
        checkOutput("async_rst.circ", int'(value_c), 0);
        #3;
        rstnn = 1'b1;
        runCycles(1);
        checkOutput("resume.1", int'(value_s), 1);
        runCycles(1);
        checkOutput("resume.2", int'(value_s), 2);
        checkOutput("one.wrapped", int'(value_1), 0);

        // Reach terminal, then saturate versus wrap.
        runCycles(61);
        checkOutput("term.sat.value", int'(value_s), 63);
        checkOutput("term.sat.last", int'(last_s), 1);
        checkOutput("term.circ.value", int'(value_c), 63);
        runCycles(1);
        checkOutput("wrap.circ.value", int'(value_c), 0);
        checkOutput("wrap.circ.first", int'(first_c), 1);
        checkOutput("wrap.circ.last", int'(last_c), 0);
        checkOutput("sat.hold1", int'(value_s), 63);
        runCycles(4);
        checkOutput("sat.hold5", int'(value_s), 63);
        checkOutput("circ.after5", int'(value_c), 4);

        // init beats count.
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(1);
        checkOutput("init.clear", int'(value_s), 0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        runCycles(40);
        checkOutput("count40", int'(value_s), 40);
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(1);
        checkOutput("init_over_count.sat", int'(value_s), 0);
        checkOutput("init_over_count.circ", int'(value_c), 0);

        // enable low freezes the count, including against init.
        applyStimulus(1'b1, 1'b0, 1'b1);
        runCycles(5);
        checkOutput("count5", int'(value_s), 5);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runCycles(10);
        checkOutput("disabled.count", int'(value_s), 5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCycles(2);
        checkOutput("disabled.init", int'(value_s), 5);

        // Reset-controller loop: init fed back from is_last_count.
        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(1);
        loop_on = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 128; i++) begin
            runCycles(1);
            if (last_c) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
                else if (second_pulse < 0) second_pulse = i;
            end
        end
        checkOutput("loop.pulses", pulses, 2);
        checkOutput("loop.first_pulse", first_pulse, 63);
        checkOutput("loop.period", second_pulse - first_pulse, 64);
        checkOutput("loop.end.circ", int'(value_c), 0);
        checkOutput("loop.end.sat", int'(value_s), 0);

        loop_on = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        runCycles(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
